// File: rtl/rle_enc_param.sv
// rtl/rle_enc_param.sv - parametrised LSB-first run-length encoder, FIFO in / FIFO out
// Optional statistics counters are enabled by defining RLE_STATS_EN.
module rle_enc_param #(
  parameter int IN_W  = 8,
  parameter int CNT_W = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             recv_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             rd_req,
  input  logic             end_of_stream,
  input  logic             send_ready,
  output logic             wr_req,
  output logic [CNT_W:0]   out_data,
  output logic             busy
`ifdef RLE_STATS_EN
  ,
  output logic [31:0]      stat_words,
  output logic [31:0]      stat_tokens
`endif
);

  localparam int IDX_W = $clog2(IN_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_LOAD, S_SCAN, S_EMIT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              rd_req_q, rd_req_d;
  logic              wr_req_q, wr_req_d;
  logic [CNT_W:0]    out_data_q, out_data_d;
  logic [IN_W-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              value_q, value_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              final_q, final_d;
`ifdef RLE_STATS_EN
  logic [31:0]       stat_words_q, stat_words_d;
  logic [31:0]       stat_tokens_q, stat_tokens_d;
`endif

  always_comb begin
    state_d    = state_q;
    rd_req_d   = 1'b0;
    wr_req_d   = 1'b0;
    out_data_d = out_data_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    value_d    = value_q;
    count_d    = count_q;
    final_d    = final_q;
`ifdef RLE_STATS_EN
    stat_words_d  = stat_words_q;
    stat_tokens_d = stat_tokens_q;
`endif
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (recv_ready) begin
          rd_req_d = 1'b1;
          state_d  = S_WAIT;
        end else if (end_of_stream) begin
          if (count_q != '0) begin
            final_d = 1'b1;
            state_d = S_EMIT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WAIT: state_d = S_LOAD;
      S_LOAD: begin
        shift_d = in_data;
        idx_d   = '0;
        state_d = S_SCAN;
`ifdef RLE_STATS_EN
        stat_words_d = stat_words_q + 32'd1;
`endif
      end
      S_SCAN: begin
        // A mismatching or saturating bit is left in place so it seeds the next run
        if (count_q == '0 || (shift_q[0] == value_q && count_q != CNT_MAX)) begin
          if (count_q == '0) value_d = shift_q[0];
          count_d = count_q + 1'b1;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = S_REQ;
        end else begin
          final_d = 1'b0;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (send_ready) begin
          out_data_d = {value_q, count_q};
          wr_req_d   = 1'b1;
          count_d    = '0;
          state_d    = final_q ? S_DONE : S_SCAN;
`ifdef RLE_STATS_EN
          stat_tokens_d = stat_tokens_q + 32'd1;
`endif
        end
      end
      S_DONE: begin
        count_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rd_req_q   <= 1'b0;
      wr_req_q   <= 1'b0;
      out_data_q <= '0;
      shift_q    <= '0;
      idx_q      <= '0;
      value_q    <= 1'b0;
      count_q    <= '0;
      final_q    <= 1'b0;
`ifdef RLE_STATS_EN
      stat_words_q  <= '0;
      stat_tokens_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rd_req_q   <= rd_req_d;
      wr_req_q   <= wr_req_d;
      out_data_q <= out_data_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      value_q    <= value_d;
      count_q    <= count_d;
      final_q    <= final_d;
`ifdef RLE_STATS_EN
      stat_words_q  <= stat_words_d;
      stat_tokens_q <= stat_tokens_d;
`endif
    end
  end

  assign rd_req   = rd_req_q;
  assign wr_req   = wr_req_q;
  assign out_data = out_data_q;
  assign busy     = (state_q != S_IDLE);
`ifdef RLE_STATS_EN
  assign stat_words  = stat_words_q;
  assign stat_tokens = stat_tokens_q;
`endif

endmodule
